// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-access stage: data-memory request handshake, store lane
//            replication / byte strobes, load extraction and pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ready_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam logic [1:0] c_idle      = 2'd0;
  localparam logic [1:0] c_wait_ack  = 2'd1;
  localparam logic [1:0] c_wait_data = 2'd2;
  localparam logic [1:0] c_done      = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic [31:0] r_rdata;

  logic        w_access;
  logic        w_is_b;
  logic        w_is_h;
  logic        w_aligned;
  logic        w_issue;
  logic        w_store_done;
  logic        w_in_idle;
  logic        w_in_ack;
  logic        w_in_data;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  // Size comes from funct3[1:0]; 011/110/111 all fall through to word.
  assign w_is_b    = (funct3_i[1:0] == 2'b00);
  assign w_is_h    = (funct3_i[1:0] == 2'b01);
  assign w_aligned = w_is_b
                   | (w_is_h & ~alu_out_i[0])
                   | (~w_is_b & ~w_is_h & (alu_out_i[1:0] == 2'b00));

  assign w_access     = ex_valid_i & (mem_rd_i | mem_wr_i);
  assign w_in_idle    = (r_state == c_idle);
  assign w_in_ack     = (r_state == c_wait_ack);
  assign w_in_data    = (r_state == c_wait_data);
  assign w_issue      = w_in_idle & w_access & w_aligned;
  assign w_store_done = mem_wr_i & dmem_ready_i;

  // Gating with rst_n drops the request and stall the moment reset asserts.
  assign dmem_req_o  = rst_n & (w_issue | w_in_ack);
  assign stall_o     = rst_n & ((w_issue & ~w_store_done)
                              | (w_in_ack & ~w_store_done)
                              | w_in_data);
  assign misalign_o  = rst_n & w_in_idle & w_access & ~w_aligned;

  assign dmem_we_o    = mem_wr_i;
  assign dmem_addr_o  = {alu_out_i[31:2], 2'b00};
  assign dmem_wdata_o = w_wdata;
  assign dmem_wstrb_o = (dmem_req_o & mem_wr_i) ? w_strb : 4'b0000;

  always_comb begin
    w_wdata = rs2_data_i;
    w_strb  = 4'b1111;
    if (w_is_b) begin
      w_wdata = {4{rs2_data_i[7:0]}};
      w_strb  = 4'b0001 << alu_out_i[1:0];
    end else if (w_is_h) begin
      w_wdata = {2{rs2_data_i[15:0]}};
      w_strb  = alu_out_i[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Extraction uses the offset latched at issue, not the live address.
  assign w_shift = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ext = dmem_rdata_i;
    case (r_f3[1:0])
      2'b00:   w_ext = {{24{~r_f3[2] & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ext = {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_issue) begin
          if (!dmem_ready_i)   w_next = c_wait_ack;
          else if (!mem_wr_i)  w_next = c_wait_data;
        end
      end
      c_wait_ack: begin
        if (dmem_ready_i) w_next = mem_wr_i ? c_idle : c_wait_data;
      end
      c_wait_data: begin
        if (dmem_rvalid_i) w_next = c_done;
      end
      default: w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_off   <= 2'b00;
      r_f3    <= 3'b000;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_off <= alu_out_i[1:0];
        r_f3  <= funct3_i;
      end
      if (w_in_data && dmem_rvalid_i) begin
        r_rdata <= w_ext;
      end
    end
  end

  assign mem_rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed self-checking bench for mem_access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic [31:0] alu_out_i;
  logic [31:0] rs2_data_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_ready_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] mem_rdata_o;
  logic        stall_o;
  logic        misalign_o;

  int n_checks;
  int n_errors;

  mem_access dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid_i),
    .alu_out_i    (alu_out_i),
    .rs2_data_i   (rs2_data_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .funct3_i     (funct3_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wstrb_o (dmem_wstrb_o),
    .dmem_ready_i (dmem_ready_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .mem_rdata_o  (mem_rdata_o),
    .stall_o      (stall_o),
    .misalign_o   (misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_i    = 1'b0;
    mem_rd_i      = 1'b0;
    mem_wr_i      = 1'b0;
    alu_out_i     = 32'h0;
    rs2_data_i    = 32'h0;
    funct3_i      = 3'b000;
    dmem_ready_i  = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  // Load with ack_wait ready-low cycles, rvalid lat cycles after acceptance.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input int ack_wait, input int lat,
                          input logic [31:0] exp);
    ex_valid_i    = 1'b1;
    mem_rd_i      = 1'b1;
    mem_wr_i      = 1'b0;
    alu_out_i     = addr;
    funct3_i      = f3;
    dmem_ready_i  = (ack_wait == 0);
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h5A5A_5A5A;
    #1;
    check({tag, " issue req"},   {31'b0, dmem_req_o}, 32'd1);
    check({tag, " issue addr"},  dmem_addr_o, {addr[31:2], 2'b00});
    check({tag, " issue wstrb"}, {28'b0, dmem_wstrb_o}, 32'd0);
    check({tag, " issue stall"}, {31'b0, stall_o}, 32'd1);
    for (int j = 1; j <= ack_wait; j++) begin
      step();
      dmem_ready_i = (j == ack_wait);
      #1;
      check({tag, " ack req"},   {31'b0, dmem_req_o}, 32'd1);
      check({tag, " ack stall"}, {31'b0, stall_o}, 32'd1);
    end
    for (int j = 1; j <= lat; j++) begin
      step();
      dmem_ready_i  = 1'b0;
      dmem_rvalid_i = (j == lat);
      dmem_rdata_i  = (j == lat) ? rdata : 32'h5A5A_5A5A;
      #1;
      check({tag, " data req"},   {31'b0, dmem_req_o}, 32'd0);
      check({tag, " data stall"}, {31'b0, stall_o}, 32'd1);
    end
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    check({tag, " done stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, " done req"},   {31'b0, dmem_req_o}, 32'd0);
    check({tag, " done rdata"}, mem_rdata_o, exp);
    step();
    idle_inputs();
    #1;
    check({tag, " after stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, " after rdata"}, mem_rdata_o, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();
    #3;
    check("reset req",      {31'b0, dmem_req_o}, 32'd0);
    check("reset stall",    {31'b0, stall_o}, 32'd0);
    check("reset misalign", {31'b0, misalign_o}, 32'd0);
    check("reset rdata",    mem_rdata_o, 32'd0);
    #9 rst_n = 1'b1;
    step();

    // SW, ready immediately
    ex_valid_i = 1'b1; mem_wr_i = 1'b1; alu_out_i = 32'h100;
    rs2_data_i = 32'hDEAD_BEEF; funct3_i = 3'b010; dmem_ready_i = 1'b1;
    #1;
    check("sw req",   {31'b0, dmem_req_o}, 32'd1);
    check("sw we",    {31'b0, dmem_we_o}, 32'd1);
    check("sw addr",  dmem_addr_o, 32'h100);
    check("sw wdata", dmem_wdata_o, 32'hDEAD_BEEF);
    check("sw wstrb", {28'b0, dmem_wstrb_o}, 32'hF);
    check("sw stall", {31'b0, stall_o}, 32'd0);
    step();
    idle_inputs();
    #1;
    check("sw after req",   {31'b0, dmem_req_o}, 32'd0);
    check("sw after stall", {31'b0, stall_o}, 32'd0);

    // SB at 0x103 with two ready-low cycles
    ex_valid_i = 1'b1; mem_wr_i = 1'b1; alu_out_i = 32'h103;
    rs2_data_i = 32'h0000_00A5; funct3_i = 3'b000; dmem_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      dmem_ready_i = (c == 2);
      #1;
      check("sb req",   {31'b0, dmem_req_o}, 32'd1);
      check("sb addr",  dmem_addr_o, 32'h100);
      check("sb wdata", dmem_wdata_o, 32'hA5A5_A5A5);
      check("sb wstrb", {28'b0, dmem_wstrb_o}, 32'h8);
      check("sb stall", {31'b0, stall_o}, (c == 2) ? 32'd0 : 32'd1);
    end
    step();
    idle_inputs();
    #1;
    check("sb after req",   {31'b0, dmem_req_o}, 32'd0);
    check("sb after stall", {31'b0, stall_o}, 32'd0);

    // SH at 0x102 lane/strobe
    ex_valid_i = 1'b1; mem_wr_i = 1'b1; alu_out_i = 32'h102;
    rs2_data_i = 32'h1234_ABCD; funct3_i = 3'b001; dmem_ready_i = 1'b1;
    #1;
    check("sh wdata", dmem_wdata_o, 32'hABCD_ABCD);
    check("sh wstrb", {28'b0, dmem_wstrb_o}, 32'hC);
    step();
    idle_inputs();

    run_load("lb",  32'h102, 3'b000, 32'h0080_0000, 0, 2, 32'hFFFF_FF80);
    run_load("lbu", 32'h102, 3'b100, 32'h0080_0000, 0, 2, 32'h0000_0080);
    run_load("lh",  32'h102, 3'b001, 32'h8001_0000, 0, 1, 32'hFFFF_8001);
    run_load("lhu", 32'h102, 3'b101, 32'h8001_0000, 1, 1, 32'h0000_8001);
    run_load("lw",  32'h104, 3'b010, 32'h1234_5678, 2, 1, 32'h1234_5678);
    run_load("lb0", 32'h201, 3'b000, 32'h0000_7F00, 0, 1, 32'h0000_007F);

    // Non-memory instruction: rvalid ignored, result held
    ex_valid_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("nonmem stall", {31'b0, stall_o}, 32'd0);
    check("nonmem req",   {31'b0, dmem_req_o}, 32'd0);
    step();
    idle_inputs();
    #1;
    check("nonmem rdata", mem_rdata_o, 32'h0000_007F);

    // Misaligned LW and SH
    ex_valid_i = 1'b1; mem_rd_i = 1'b1; alu_out_i = 32'h101;
    funct3_i = 3'b010; dmem_ready_i = 1'b1;
    #1;
    check("lw mis misalign", {31'b0, misalign_o}, 32'd1);
    check("lw mis req",      {31'b0, dmem_req_o}, 32'd0);
    check("lw mis stall",    {31'b0, stall_o}, 32'd0);
    step();
    mem_rd_i = 1'b0; mem_wr_i = 1'b1; alu_out_i = 32'h0FF;
    funct3_i = 3'b001; rs2_data_i = 32'h0000_BEEF;
    #1;
    check("sh mis misalign", {31'b0, misalign_o}, 32'd1);
    check("sh mis req",      {31'b0, dmem_req_o}, 32'd0);
    check("sh mis wstrb",    {28'b0, dmem_wstrb_o}, 32'd0);
    check("sh mis stall",    {31'b0, stall_o}, 32'd0);
    step();
    idle_inputs();
    #1;
    check("mis clear", {31'b0, misalign_o}, 32'd0);

    // Reset asserted while waiting for read data
    ex_valid_i = 1'b1; mem_rd_i = 1'b1; alu_out_i = 32'h104;
    funct3_i = 3'b010; dmem_ready_i = 1'b1;
    step();
    dmem_ready_i = 1'b0;
    #1;
    check("rst pre stall", {31'b0, stall_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst stall", {31'b0, stall_o}, 32'd0);
    check("rst req",   {31'b0, dmem_req_o}, 32'd0);
    check("rst rdata", mem_rdata_o, 32'd0);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_BABE;
    #1;
    check("post rst stall", {31'b0, stall_o}, 32'd0);
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    check("post rst rdata", mem_rdata_o, 32'd0);
    check("post rst stall2", {31'b0, stall_o}, 32'd0);

    run_load("lw2", 32'h200, 3'b011, 32'h8765_4321, 0, 1, 32'h8765_4321);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access stage logic for the 5-stage core, sitting between the execute→memory pipeline register and the memory→write-back pipeline register. Issues load/store requests to the data memory over a valid/ready request channel with a separate read-data return, and generates byte strobes and store-lane replication. Sign- or zero-extends load data and stalls the pipeline until each access completes. Its outputs feed the write-back register's memory-read-data input, and its stall freezes all upstream stages.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ex_valid_i  input  1  instruction in memory stage is valid
- alu_out_i  input  32  effective address (ALU result)
- rs2_data_i  input  32  store data
- mem_rd_i  input  1  instruction is a load
- mem_wr_i  input  1  instruction is a store
- funct3_i  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- dmem_req_o  output  1  request valid
- dmem_we_o  output  1  1 = write, 0 = read
- dmem_addr_o  output  32  word address, {alu_out_i[31:2], 2'b00}
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_wstrb_o  output  4  byte strobes (0 for reads)
- dmem_ready_i  input  1  memory accepts request this cycle
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  32  read data word
- mem_rdata_o  output  32  extended load result, registered
- stall_o  output  1  hold all upstream pipeline registers
- misalign_o  output  1  misaligned access detected this cycle

## Operation
- Access = ex_valid_i & (mem_rd_i | mem_wr_i). If both rd and wr are set, the access is a store.
- Alignment: W needs addr[1:0]=00; H/HU need addr[0]=0; B always aligned. funct3 values 011/110/111 are treated as W.
- States: IDLE, WAIT_ACK, WAIT_DATA, DONE.
- IDLE: an aligned access drives dmem_req_o=1 combinationally and latches addr[1:0]/funct3 into offset registers.
  - Ready=1, store → stay IDLE, stall_o=0.
  - Ready=1, load → WAIT_DATA.
  - Ready=0 → WAIT_ACK.
- WAIT_ACK: dmem_req_o held with stable addr/we/wdata/wstrb until ready.
  - Store on ready → IDLE, stall_o=0 that cycle.
  - Load on ready → WAIT_DATA.
- WAIT_DATA: req=0. On rvalid, the extended data is captured into mem_rdata_o → DONE. rvalid is ignored in all other states.
- DONE: stall_o=0 for one cycle so the write-back register captures mem_rdata_o → IDLE.
- stall_o = (IDLE & aligned access & ~(store & ready)) | WAIT_ACK & ~(store & ready) | WAIT_DATA.
- Misaligned access: no request; misalign_o=1 that cycle; stall_o=0; store suppressed.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=0011 or 1100 by addr[1].
  - SW: rs2, 1111.
- Load extract: shift rdata right by 8·offset. B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
- Upstream inputs are held stable while stall_o=1. The offset registers are still used for extraction.

## Timing
- Reset (async): state=IDLE, mem_rdata_o=0. The offset registers clear. With no access present, dmem_req_o=0, stall_o=0 and misalign_o=0. Asserting reset mid-transaction drops the request immediately; any in-flight rvalid after release is ignored.
- Store, ready immediate: 1 cycle, no stall. Each ready-low cycle adds 1 stall cycle.
- Load minimum: 3 cycles (accept, rvalid the next cycle, DONE), with 2 stall cycles. rvalid never arrives in the accept cycle.
- Non-memory instructions: no stall; mem_rdata_o holds its last captured value.

## Test plan
- SW addr 0x100, rs2 0xDEADBEEF, ready=1 → req, we=1, addr 0x100, wstrb 1111, stall_o=0 for 1 cycle.
- SB addr 0x103, rs2 0x000000A5, ready low for 2 cycles → wdata 0xA5A5A5A5, wstrb 1000 held stable, stall_o=1 for 2 cycles then 0.
- LB addr 0x102, rdata 0x00800000, rvalid 2 cycles after accept → mem_rdata_o=0xFFFFFF80 in DONE, stall_o=1 until DONE. LBU at the same address → 0x00000080.
- LH addr 0x102, rdata 0x8001_0000 → 0xFFFF8001. LHU → 0x00008001.
- LW addr 0x101 → misalign_o=1, dmem_req_o=0, stall_o=0. SH addr 0x0FF → no write.
- rst_n low during WAIT_DATA → state IDLE, stall_o=0, mem_rdata_o=0. A later rvalid is ignored.
